// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole wave generator.
package mole_pkg;

    typedef logic [17:0] mole_mask_t;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        ACTIVE,
        REPORT,
        GAP
    } wave_state_t;

    localparam mole_mask_t LFSR_SEED = 18'h2A5F3;
    localparam int         LFSR_TAP  = 11;

    // Sparse mask from the LFSR; falls back to a single mole so a wave is never empty.
    function automatic mole_mask_t spawn_mask(input mole_mask_t l);
        mole_mask_t m;
        m = l & {l[8:0], l[17:9]};
        if (m == '0) begin
            if (l[4:0] < 5'd18) begin
                m = mole_mask_t'(1) << l[4:0];
            end else begin
                m = mole_mask_t'(1);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 18-bit Fibonacci LFSR, polynomial x^18 + x^11 + 1.
module mole_lfsr
    import mole_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output mole_mask_t o_lfsr
);

    mole_mask_t r_lfsr;
    logic       w_fb;

    assign w_fb = r_lfsr[17] ^ r_lfsr[LFSR_TAP-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[16:0], w_fb};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/mole_wave_gen.sv
// Mole wave generator: spawns random waves, records switch strikes,
// and reports the hit mask once per wave.
module mole_wave_gen
    import mole_pkg::*;
#(
    parameter int N_MOLES    = 18,
    parameter int WAVE_TICKS = 1000,
    parameter int GAP_TICKS  = 250,
    parameter int N_WAVES    = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               tick,
    input  logic [N_MOLES-1:0] sw,
    output logic [N_MOLES-1:0] led_moles,
    output logic [N_MOLES-1:0] hit_reg,
    output logic               wave_done,
    output logic               game_over,
    output logic               busy
);

    wave_state_t r_state, w_state_nxt;
    mole_mask_t  r_sync1, r_sync2, r_prev;
    mole_mask_t  r_led, r_hits;
    logic [15:0] r_tick_cnt;
    logic [7:0]  r_wave_cnt;
    logic        r_game_over;

    mole_mask_t  w_lfsr, w_toggle, w_strike;
    mole_mask_t  w_led_nxt, w_hits_nxt;
    logic [15:0] w_tick_nxt;
    logic [7:0]  w_wave_nxt;
    logic        w_over_nxt;
    logic        w_wave_end, w_gap_end;

    mole_lfsr u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .o_lfsr (w_lfsr)
    );

    assign w_toggle   = r_sync2 ^ r_prev;
    assign w_strike   = w_toggle & r_led;
    assign w_wave_end = tick && (r_tick_cnt == 16'(WAVE_TICKS - 1));
    assign w_gap_end  = tick && (r_tick_cnt == 16'(GAP_TICKS - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_led_nxt   = r_led;
        w_hits_nxt  = r_hits;
        w_tick_nxt  = r_tick_cnt;
        w_wave_nxt  = r_wave_cnt;
        w_over_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SPAWN;
                    w_wave_nxt  = '0;
                end
            end
            SPAWN: begin
                w_led_nxt   = spawn_mask(w_lfsr);
                w_hits_nxt  = '0;
                w_tick_nxt  = '0;
                w_state_nxt = ACTIVE;
            end
            ACTIVE: begin
                // Strikes landing on the timeout cycle are still credited.
                w_hits_nxt = r_hits | w_strike;
                w_led_nxt  = r_led & ~w_strike;
                if (tick) begin
                    w_tick_nxt = r_tick_cnt + 16'd1;
                end
                if (r_led == '0 || w_wave_end) begin
                    w_state_nxt = REPORT;
                end
            end
            REPORT: begin
                w_led_nxt   = '0;
                w_wave_nxt  = r_wave_cnt + 8'd1;
                w_tick_nxt  = '0;
                w_state_nxt = GAP;
            end
            GAP: begin
                if (tick) begin
                    w_tick_nxt = r_tick_cnt + 16'd1;
                    if (w_gap_end) begin
                        if (r_wave_cnt == 8'(N_WAVES)) begin
                            w_over_nxt  = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = SPAWN;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1     <= sw;
            r_sync2     <= sw;
            r_prev      <= sw;
            r_led       <= '0;
            r_hits      <= '0;
            r_tick_cnt  <= '0;
            r_wave_cnt  <= '0;
            r_game_over <= 1'b0;
        end else begin
            r_sync1     <= sw;
            r_sync2     <= r_sync1;
            r_prev      <= r_sync2;
            r_led       <= w_led_nxt;
            r_hits      <= w_hits_nxt;
            r_tick_cnt  <= w_tick_nxt;
            r_wave_cnt  <= w_wave_nxt;
            r_game_over <= w_over_nxt;
        end
    end

    assign led_moles = r_led;
    assign hit_reg   = (r_state == REPORT) ? r_hits : '0;
    assign wave_done = (r_state == REPORT);
    assign game_over = r_game_over;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mole_wave_gen.sv
// Randomized bench for mole_wave_gen with a cycle-level reference model.
module tb_mole_wave_gen;

    localparam int WT = 4;
    localparam int GT = 2;
    localparam int NW = 2;
    localparam int P_IDLE = 0, P_SPAWN = 1, P_ACTIVE = 2, P_REPORT = 3, P_GAP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        tick = 1'b0;
    logic [17:0] sw = '0;
    logic [17:0] led_moles, hit_reg;
    logic        wave_done, game_over, busy;

    int checks = 0;
    int failures = 0;
    int n_wd = 0;
    int n_go = 0;

    // reference model state
    int          ph = P_IDLE;
    int          m_tc = 0;
    int          m_waves = 0;
    bit          m_go = 1'b0;
    bit          m_valid = 1'b0;
    logic [17:0] m_lfsr = '0, m_s1 = '0, m_s2 = '0, m_prev = '0;
    logic [17:0] m_led = '0, m_hits = '0;

    // stimulus bookkeeping
    int          widx = 0;
    int          prev_ph = P_IDLE;
    logic [17:0] tg = '0;
    logic [17:0] wave_mask = '0;
    bit          struck = 1'b0;
    bit          cap = 1'b0;
    int          modes [5] = '{0, 1, 2, 3, 4};

    mole_wave_gen #(
        .N_MOLES    (18),
        .WAVE_TICKS (WT),
        .GAP_TICKS  (GT),
        .N_WAVES    (NW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .tick      (tick),
        .sw        (sw),
        .led_moles (led_moles),
        .hit_reg   (hit_reg),
        .wave_done (wave_done),
        .game_over (game_over),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] ref_next(input logic [17:0] l);
        return {l[16:0], l[17] ^ l[10]};
    endfunction

    function automatic logic [17:0] ref_mask(input logic [17:0] l);
        logic [17:0] m;
        int idx;
        m = l & ((l << 9) | (l >> 9));
        if (m == 0) begin
            idx = int'(l[4:0]);
            m = (idx < 18) ? (18'd1 << idx) : 18'd1;
        end
        return m;
    endfunction

    function automatic logic [17:0] lowbit(input logic [17:0] v);
        return v & (~v + 18'd1);
    endfunction

    task automatic model_step();
        logic [17:0] tog, hit;
        tog = m_s2 ^ m_prev;
        if (!reset) begin
            ph = P_IDLE;
            m_led = '0;
            m_hits = '0;
            m_tc = 0;
            m_waves = 0;
            m_go = 1'b0;
            m_lfsr = 18'h2A5F3;
            m_s1 = sw;
            m_s2 = sw;
            m_prev = sw;
            m_valid = 1'b1;
        end else begin
            m_go = 1'b0;
            case (ph)
                P_IDLE: if (start) begin
                    ph = P_SPAWN;
                    m_waves = 0;
                end
                P_SPAWN: begin
                    m_led = ref_mask(m_lfsr);
                    m_hits = '0;
                    m_tc = 0;
                    ph = P_ACTIVE;
                end
                P_ACTIVE: begin
                    hit = tog & m_led;
                    if (m_led == 0 || (tick && m_tc + 1 == WT)) ph = P_REPORT;
                    m_hits = m_hits | hit;
                    m_led = m_led & ~hit;
                    if (tick) m_tc++;
                end
                P_REPORT: begin
                    m_led = '0;
                    m_waves++;
                    m_tc = 0;
                    ph = P_GAP;
                end
                default: if (tick) begin
                    m_tc++;
                    if (m_tc == GT) begin
                        if (m_waves == NW) begin
                            m_go = 1'b1;
                            ph = P_IDLE;
                        end else begin
                            ph = P_SPAWN;
                        end
                    end
                end
            endcase
            m_lfsr = ref_next(m_lfsr);
            m_prev = m_s2;
            m_s2 = m_s1;
            m_s1 = sw;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial begin : ticker
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            tick = (k % 4 == 0);
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("led_moles", led_moles, m_led);
            chk("hit_reg", hit_reg, (ph == P_REPORT) ? m_hits : 18'd0);
            chk("wave_done", 18'(wave_done), 18'(ph == P_REPORT));
            chk("game_over", 18'(game_over), 18'(m_go));
            chk("busy", 18'(busy), 18'(ph != P_IDLE));
            if (wave_done) n_wd++;
            if (game_over) n_go++;
        end
    end

    task automatic stim();
        logic [17:0] lit, b, r;
        int md;
        md = (widx < 5) ? modes[widx] : 1;
        if (ph == P_SPAWN) begin
            tg = '0;
            struck = 1'b0;
            cap = 1'b0;
        end
        if (ph == P_ACTIVE && !cap) begin
            wave_mask = m_led;
            cap = 1'b1;
        end
        if (ph == P_REPORT) begin
            if (md == 0) chk("allhit_mask", hit_reg, wave_mask);
            if (md == 1) chk("timeout_nohit", hit_reg, 18'd0);
            if (md == 2) chk("single_hit_onehot", 18'($countones(hit_reg)), 18'd1);
            widx++;
        end
        if (ph == P_ACTIVE) begin
            lit = m_led & ~tg;
            case (md)
                0: for (int j = 0; j < 3; j++) begin
                    b = lowbit(lit);
                    sw ^= b;
                    tg |= b;
                    lit &= ~b;
                end
                2: if (!struck) begin
                    r = 18'($urandom);
                    b = lowbit(lit);
                    sw ^= (r & ~m_led) | b;
                    tg |= b;
                    struck = 1'b1;
                end
                3: if ($urandom_range(0, 2) == 0) sw ^= 18'($urandom & $urandom);
                4: if (!struck) begin
                    sw ^= lowbit(lit);
                    struck = 1'b1;
                end
                default: ;
            endcase
        end else if (ph == P_GAP && prev_ph == P_REPORT) begin
            sw ^= 18'($urandom) | 18'd1;
        end
        prev_ph = ph;
    endtask

    initial begin : main
        logic [17:0] v;
        bit aborted;
        v = 18'h2A5F3;
        chk("pin_mask_seed", ref_mask(v), 18'h2A552);
        chk("pin_lfsr_step", ref_next(v), 18'h14BE6);
        v = 18'h00003;
        chk("pin_mask_fallback", ref_mask(v), 18'h00008);
        v = 18'h00015;
        chk("pin_mask_fallback_hi", ref_mask(v), 18'h00001);

        sw = 18'($urandom);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i < 40 && $urandom_range(0, 3) == 0) sw ^= 18'($urandom);
        end

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3000 && n_go < 2; c++) begin
            @(negedge clk);
            if (n_go == 0 && widx >= 1) start = 1'b1;
            if (n_go >= 1 && ph != P_IDLE) start = 1'b0;
            stim();
        end
        start = 1'b0;
        chk("game_over_count", 18'(n_go), 18'd2);
        chk("wave_done_count", 18'(n_wd), 18'd4);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        aborted = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            stim();
            if (ph == P_ACTIVE && m_hits != 0) begin
                aborted = 1'b1;
                break;
            end
        end
        chk("abort_point_reached", 18'(aborted), 18'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 18'(busy), 18'd0);
        chk("abort_leds", led_moles, 18'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_report", 18'(n_wd), 18'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
